// File: rtl/accel_spi_slave_if.sv
// SPI pin bundle between an external SPI master and the accelerometer slave.
// The master drives chip select, clock and MOSI; the slave returns MISO.
interface accel_spi_slave_if;
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sclk, output mosi, input miso);
  modport slave  (input cs_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/accel_spi_slave.sv
// Accelerometer-style SPI mode-0 register slave running on HCLK.
// SPI pins are oversampled through 2-flop synchronisers. Commands 0x0A (write)
// and 0x0B (read) are followed by an address byte and an auto-incrementing data burst.
// Samples arriving mid-transaction are parked so that the data registers stay
// coherent for the whole transaction.
module accel_spi_slave #(
  parameter logic [7:0]  DEVID    = 8'hAD,
  parameter int unsigned MIN_HALF = 6
) (
  input  logic             hclk_i,
  input  logic             hreset_i,
  accel_spi_slave_if.slave spi,
  input  logic             sample_valid_i,
  input  logic [7:0]       sample_x_i,
  input  logic [7:0]       sample_y_i,
  input  logic [7:0]       sample_z_i,
  output logic [7:0]       power_ctl_o,
  output logic             busy_o
);

  // The reset values in the synchronisers must not look like a CS_N edge, so
  // edge detection is held off for a few cycles after reset (never < 3 cycles).
  localparam int unsigned      WARM_CYC = (MIN_HALF > 3) ? MIN_HALF : 3;
  localparam int unsigned      WARM_W   = $clog2(WARM_CYC + 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARM_CYC);
  localparam logic [WARM_W-1:0] WARM_ONE = WARM_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_e;

  // Synchroniser and edge-detect state
  logic              cs_meta_q, cs_sync_q, cs_prev_q;
  logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic              mosi_meta_q, mosi_sync_q;
  logic [WARM_W-1:0] warm_q;

  // Protocol state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       is_read_q, is_read_d;
  logic       miso_q, miso_d;
  logic       busy_q;

  // Register file and pending sample buffer
  logic [7:0] power_q, power_d;
  logic [7:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic       drdy_q, drdy_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;

  logic       warm_done_s, cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic       byte_done_s, drdy_clr_s, load_s, idle_s;
  logic [7:0] rx_byte_s, addr_inc_s;

  // Register map read mux.
  function automatic logic [7:0] reg_read(input logic [7:0] a, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] z,
                                          input logic drdy, input logic [7:0] pwr);
    case (a)
      8'h00:   reg_read = DEVID;
      8'h08:   reg_read = x;
      8'h09:   reg_read = y;
      8'h0A:   reg_read = z;
      8'h0B:   reg_read = {7'b0000000, drdy};
      8'h2D:   reg_read = pwr;
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign warm_done_s = (warm_q == WARM_MAX);
  assign cs_fall_s   = warm_done_s & cs_prev_q & ~cs_sync_q;
  assign cs_rise_s   = ~cs_prev_q & cs_sync_q;
  assign sclk_rise_s = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_sync_q & sclk_prev_q;
  assign rx_byte_s   = {rx_q[6:0], mosi_sync_q};
  assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd7);
  assign addr_inc_s  = addr_q + 8'd1;
  assign idle_s      = (state_q == ST_IDLE);

  assign spi.miso    = miso_q;
  assign power_ctl_o = power_q;
  assign busy_o      = busy_q;

  // Bring the SPI pins into the HCLK domain and keep last values for edge detection.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      warm_q      <= {WARM_W{1'b0}};
    end else begin
      cs_meta_q   <= spi.cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= spi.sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi.mosi;
      mosi_sync_q <= mosi_meta_q;
      if (warm_q != WARM_MAX) begin
        warm_q <= warm_q + WARM_ONE;
      end
    end
  end

  // Transaction FSM: byte assembly, command/address decode, burst shift-out and writes.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    is_read_d  = is_read_q;
    power_d    = power_q;
    drdy_clr_s = 1'b0;
    if (cs_rise_s) begin
      // Deselect aborts everything, including a partially received byte.
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
    end else begin
      if (!idle_s && sclk_rise_s) begin
        rx_d      = rx_byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        rx_d = rx_q;
      end
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          if (cs_fall_s) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            if (rx_byte_s == 8'h0A) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR;
            end else if (rx_byte_s == 8'h0B) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (byte_done_s) begin
            addr_d  = rx_byte_s;
            state_d = ST_DATA;
            if (is_read_q) begin
              tx_d = reg_read(rx_byte_s, x_q, y_q, z_q, drdy_q, power_q);
            end else begin
              tx_d = 8'h00;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (byte_done_s) begin
            addr_d = addr_inc_s;
            if (is_read_q) begin
              tx_d       = reg_read(addr_inc_s, x_q, y_q, z_q, drdy_q, power_q);
              drdy_clr_s = (addr_q == 8'h0A);
            end else begin
              if (addr_q == 8'h2D) begin
                power_d = rx_byte_s;
              end else begin
                power_d = power_q;
              end
            end
          end else if (is_read_q && sclk_fall_s && (bit_cnt_q != 3'd0)) begin
            // The fall right after a byte boundary must keep the freshly loaded bit7.
            tx_d = {tx_q[6:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if ((state_d == ST_DATA) && is_read_d) begin
      miso_d = tx_d[7];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Sample capture: load directly when idle, otherwise park the latest sample.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    pend_d   = pend_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_z_d = pend_z_q;
    load_s   = 1'b0;
    if (sample_valid_i && idle_s) begin
      x_d    = sample_x_i;
      y_d    = sample_y_i;
      z_d    = sample_z_i;
      pend_d = 1'b0;
      load_s = 1'b1;
    end else if (sample_valid_i) begin
      pend_d   = 1'b1;
      pend_x_d = sample_x_i;
      pend_y_d = sample_y_i;
      pend_z_d = sample_z_i;
    end else if (pend_q && idle_s) begin
      x_d    = pend_x_q;
      y_d    = pend_y_q;
      z_d    = pend_z_q;
      pend_d = 1'b0;
      load_s = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    if (load_s) begin
      drdy_d = 1'b1;
    end else if (drdy_clr_s) begin
      drdy_d = 1'b0;
    end else begin
      drdy_d = drdy_q;
    end
  end

  // State, datapath and register-file flops.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      addr_q    <= 8'h00;
      tx_q      <= 8'h00;
      is_read_q <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      power_q   <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      z_q       <= 8'h00;
      drdy_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_x_q  <= 8'h00;
      pend_y_q  <= 8'h00;
      pend_z_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      is_read_q <= is_read_d;
      miso_q    <= miso_d;
      busy_q    <= (state_d != ST_IDLE);
      power_q   <= power_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      drdy_q    <= drdy_d;
      pend_q    <= pend_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
      pend_z_q  <= pend_z_d;
    end
  end

endmodule

// File: doc/accel_spi_slave.md
ACCEL_SPI_SLAVE -- requirements
Module: accel_spi_slave

Interface
REQ-001 Parameters (name, default, meaning): DEVID, 8'hAD, value returned at register 0x00.
REQ-002 Parameter: MIN_HALF, 6, minimum SCLK half-period in HCLK cycles that the block supports.
REQ-003 One clock; reset is asynchronous and active-high; ports, clock and reset first: HCLK  in  1  system clock.
REQ-004 HRESET  in  1  asynchronous active-high reset.
REQ-005 CS_N  in  1  chip select from SPI master, active low, asynchronous to HCLK.
REQ-006 SCLK  in  1  SPI clock, mode 0 (idle low, sample on rise), asynchronous to HCLK.
REQ-007 MOSI  in  1  serial data from master, MSB first.
REQ-008 MISO  out  1  serial data to master, MSB first, registered.
REQ-009 SAMPLE_VALID  in  1  one-cycle strobe: SAMPLE_X/Y/Z hold a new sample.
REQ-010 SAMPLE_X, SAMPLE_Y, SAMPLE_Z  in  8 each  new acceleration sample.
REQ-011 POWER_CTL  out  8  contents of register 0x2D.
REQ-012 BUSY  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 CS_N, SCLK, MOSI SHALL each pass a 2-flop synchroniser; SCLK edges SHALL be detected from the synchronised value (rise/fall = one-cycle pulses).
REQ-014 Register map SHALL be: 0x00 DEVID (RO), 0x08 XDATA, 0x09 YDATA, 0x0A ZDATA (RO), 0x0B STATUS (RO, bit0 DRDY, bits7:1 zero), 0x2D POWER_CTL (RW); all other addresses read 0x00, writes ignored.
REQ-015 FSM states SHALL be IDLE, CMD, ADDR, DATA, IGNORE; a 3-bit bit counter SHALL count rising edges per byte.
REQ-016 IDLE -> CMD on synchronised CS_N falling; bit counter cleared.
REQ-017 On each SCLK rise, MOSI SHALL shift into an 8-bit receive register; 8th rise completes a byte.
REQ-018 CMD byte 0x0A = write, 0x0B = read -> ADDR; any other value -> IGNORE.
REQ-019 ADDR byte completion SHALL latch the 8-bit address and enter DATA; for read, the shift-out register SHALL be loaded with reg[addr] and MISO driven with its bit7 in the same cycle.
REQ-020 DATA read: each SCLK fall SHALL shift the shift-out register and drive the next bit on MISO; on each byte completion address increments and shift-out reloads with reg[addr+1], bit7 driven.
REQ-021 DATA write: on byte completion, received byte written if address is 0x2D, else discarded; address then increments.
REQ-022 Address increment SHALL wrap 0xFF -> 0x00.
REQ-023 MISO SHALL be 0 in IDLE, CMD, ADDR, IGNORE and during write DATA.
REQ-024 Synchronised CS_N rising in any state SHALL return the FSM to IDLE within 1 cycle; a partial byte SHALL be discarded (no write, no increment).
REQ-025 SAMPLE_VALID with BUSY low SHALL load XDATA/YDATA/ZDATA next cycle and set DRDY.
REQ-026 SAMPLE_VALID with BUSY high SHALL store the sample in a pending buffer (latest overwrites older); pending sample SHALL be applied, DRDY set, in the cycle after return to IDLE.
REQ-027 DRDY SHALL clear when a read byte of ZDATA (0x0A) completes; if a sample load occurs the same cycle, set wins.
REQ-028 XDATA/YDATA/ZDATA SHALL be stable for the whole of a transaction (snapshot coherence).
REQ-029 Correct operation SHALL be guaranteed for SCLK half-periods >= MIN_HALF HCLK cycles; MISO SHALL update within 4 HCLK cycles of an SCLK fall at the pins.

Reset
REQ-030 HRESET high SHALL asynchronously force: FSM IDLE, counters 0, MISO 0, BUSY 0, POWER_CTL 8'h00, X/Y/ZDATA 8'h00, DRDY 0, pending buffer empty, synchronisers to CS_N=1, SCLK=0.
REQ-031 Reset asserted mid-transaction SHALL abort it; after release the block SHALL wait for a fresh CS_N falling before decoding a command.

Verification
REQ-032 Read 0x0B,0x00 then one byte, SCLK half-period 8 -> MISO returns 0xAD.
REQ-033 Write 0x0A,0x2D,0x02 -> POWER_CTL = 0x02 after 3rd byte; then write to 0x00 -> DEVID still 0xAD.
REQ-034 SAMPLE_VALID X/Y/Z=0x11/0x22/0x33 idle, then burst read from 0x08, 4 bytes -> 0x11,0x22,0x33,0x01; DRDY then 0.
REQ-035 SAMPLE_VALID 0x55/0x66/0x77 during a burst read of 0x08 -> read returns old values; after CS_N high, next read returns 0x55/0x66/0x77.
REQ-036 Command 0x0C -> MISO 0 for whole transaction, no register change; CS_N raised after 4 bits of write data -> POWER_CTL unchanged.
REQ-037 Burst read from 0xFF, 2 bytes -> 0x00 then 0xAD (wrap); HRESET mid-byte -> MISO 0, BUSY 0 immediately.
